lab2_proc_int_muldiv_iter: RTL
==============================

Name: lab2_proc_int_muldiv_iter

Overview:
- Iterative integer multiply/divide unit in the X stage, beside the ALU. It consumes the same bypassed op0/op1 operands the ALU receives.
- Serves MUL, DIV, DIVU, REM and REMU, which are too expensive for the single-cycle ALU.
- Uses val/rdy request and response interfaces. The control unit stalls X while a request is outstanding and takes the result into the X/M pipeline register on the response handshake.

Parameters:
p_nbits, 32, operand/result width; iteration count of the shift loops.

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset (asserted when 0)
req_val  input  1  request valid
req_rdy  output  1  unit can accept a request
req_msg_fn  input  3  0=MUL 1=DIV 2=DIVU 3=REM 4=REMU; 5-7 reserved
req_msg_a  input  p_nbits  op0 (multiplicand / dividend)
req_msg_b  input  p_nbits  op1 (multiplier / divisor)
resp_val  output  1  result valid
resp_rdy  input  1  consumer accepts result
resp_msg  output  p_nbits  result

Behaviour:
Reset:
- reset=0 forces, asynchronously, state=IDLE, counter=0, result register=0.
- Outputs while in reset: req_rdy=1 in IDLE, resp_val=0, resp_msg=0.
- Reset asserted in any state aborts the operation. No response is produced.

States:
- IDLE: req_rdy=1, resp_val=0. On req_val&&req_rdy at edge t, the unit latches fn, a and b.
  - Special case (divide-op with b==0, signed overflow, or reserved fn) -> DONE. resp_val=1 at t+1.
  - Otherwise load magnitudes and go to CALC with counter=0.
- CALC: req_rdy=0, resp_val=0. One iteration per cycle. counter increments; at counter==p_nbits-1 go to DONE. Response appears at t+p_nbits+1 (t+33 for 32 bits).
- DONE: resp_val=1, req_rdy=0, resp_msg held stable. On resp_rdy go to IDLE. No request is accepted in the same cycle as the response handshake.

MUL:
- Unsigned shift-add. Each cycle, if the multiplier LSB is 1, add the shifted multiplicand.
- Result is the low p_nbits of the product, which is identical for signed operands.

DIV/REM (signed):
- Operate on absolute values with restoring division: shift remainder:dividend left 1, trial-subtract divisor, set quotient bit if non-negative.
- Quotient is negated when the operand signs differ. Remainder takes the dividend's sign.

DIVU/REMU:
- Same loop, no sign fix-up.

Special results (RISC-V):
- b==0: DIV/DIVU -> all ones; REM/REMU -> a.
- DIV with a=0x80000000, b=-1 -> 0x80000000; REM with same operands -> 0.
- Reserved fn -> 0.

Widths: internal partial remainder p_nbits+1 bits; counter $clog2(p_nbits) bits; all arithmetic wraps modulo 2^p_nbits.

req_val may drop or change while the unit is busy. Latched operands are unaffected.

Decomposition:
- Shared package lab2_proc_muldiv_pkg:
  - fn encodings (MULDIV_MUL..MULDIV_REMU)
  - state enum {IDLE, CALC, DONE}
- Natural split:
  - control FSM and counter stay in the top module
  - sub-module lab2_proc_int_muldiv_dpath holds the operand, remainder and result registers, the adder/subtractor and the sign fix-up, driven by control signals from the FSM.

Test Plan:
- MUL a=7, b=0xFFFFFFFD accepted at t -> resp_val rises exactly at t+33, resp_msg=0xFFFFFFEB; req_rdy=0 during t+1..t+33.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU a=10, b=0 -> resp_val at t+1, 0xFFFFFFFF; REM a=10, b=0 -> 10; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 at t+1; REM same -> 0.
- Hold resp_rdy=0 for 5 cycles in DONE -> resp_val and resp_msg stable, req_rdy=0. Raise resp_rdy -> IDLE next cycle, req_rdy=1. A second back-to-back MUL 0x10000*0x10000 returns 0.
- Assert reset (0) mid-CALC at iteration 10 -> same cycle resp_val=0, state IDLE. After release, req_rdy=1 and a fresh MUL 3*4 returns 12.
- Random 1000 ops across all five fn values, including b=0 and operand extremes -> results match the golden model; no response is dropped or duplicated.

Source files
------------

// File: rtl/lab2_proc_muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: function
// encodings, FSM state type and small opcode classification helpers.
package lab2_proc_muldiv_pkg;

    localparam logic [2:0] MULDIV_MUL  = 3'd0;
    localparam logic [2:0] MULDIV_DIV  = 3'd1;
    localparam logic [2:0] MULDIV_DIVU = 3'd2;
    localparam logic [2:0] MULDIV_REM  = 3'd3;
    localparam logic [2:0] MULDIV_REMU = 3'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_e;

    // True for any of the four divide/remainder operations.
    function automatic logic is_divrem(input logic [2:0] fn);
        return (fn >= MULDIV_DIV) && (fn <= MULDIV_REMU);
    endfunction

    // True for the operations that treat operands as two's complement.
    function automatic logic is_signed_op(input logic [2:0] fn);
        return (fn == MULDIV_DIV) || (fn == MULDIV_REM);
    endfunction

endpackage

// File: rtl/lab2_proc_int_muldiv_dpath.sv
// Datapath of the iterative mul/div unit: operand, accumulator and result
// registers, the shift-add / restoring-divide step and the sign fix-up.
module lab2_proc_int_muldiv_dpath
    import lab2_proc_muldiv_pkg::*;
#(
    parameter int p_nbits = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               load_special,
    input  logic               step,
    input  logic               finish,
    input  logic [2:0]         req_msg_fn,
    input  logic [p_nbits-1:0] req_msg_a,
    input  logic [p_nbits-1:0] req_msg_b,
    output logic               special,
    output logic [p_nbits-1:0] resp_msg
);

    localparam logic [p_nbits-1:0] ALL_ONES = '1;
    localparam logic [p_nbits-1:0] MIN_INT  = {1'b1, {(p_nbits-1){1'b0}}};

    logic               a_neg;
    logic               b_neg;
    logic [p_nbits-1:0] a_mag;
    logic [p_nbits-1:0] b_mag;
    logic [p_nbits-1:0] special_val;

    logic [2:0]         fn_q;
    logic               neg_q;
    logic               neg_r;
    logic [p_nbits-1:0] op_a;
    logic [p_nbits-1:0] op_b;
    logic [p_nbits-1:0] acc;
    logic [p_nbits-1:0] result;

    logic [p_nbits-1:0] mul_sum;
    logic [p_nbits:0]   shifted;
    logic [p_nbits:0]   diff;
    logic               q_bit;
    logic [p_nbits-1:0] op_a_n;
    logic [p_nbits-1:0] op_b_n;
    logic [p_nbits-1:0] acc_n;
    logic [p_nbits-1:0] final_val;

    // Decode the incoming request: operand magnitudes and the cases that
    // bypass the loop (divide by zero, signed overflow, reserved fn).
    always_comb begin
        a_neg       = is_signed_op(req_msg_fn) && req_msg_a[p_nbits-1];
        b_neg       = is_signed_op(req_msg_fn) && req_msg_b[p_nbits-1];
        a_mag       = a_neg ? -req_msg_a : req_msg_a;
        b_mag       = b_neg ? -req_msg_b : req_msg_b;
        special     = 1'b0;
        special_val = '0;
        if (req_msg_fn > MULDIV_REMU) begin
            special     = 1'b1;
            special_val = '0;
        end else if (is_divrem(req_msg_fn) && (req_msg_b == '0)) begin
            special     = 1'b1;
            special_val = ((req_msg_fn == MULDIV_DIV) || (req_msg_fn == MULDIV_DIVU))
                          ? ALL_ONES : req_msg_a;
        end else if (is_signed_op(req_msg_fn) && (req_msg_a == MIN_INT)
                     && (req_msg_b == ALL_ONES)) begin
            special     = 1'b1;
            special_val = (req_msg_fn == MULDIV_DIV) ? MIN_INT : '0;
        end
    end

    // One iteration: shift-add for MUL, restoring trial subtract otherwise.
    // The partial remainder always stays below the divisor, so the trial
    // difference fits in p_nbits+1 bits and its top bit is the sign.
    always_comb begin
        mul_sum = acc + (op_b[0] ? op_a : '0);
        shifted = {acc, op_a[p_nbits-1]};
        diff    = shifted - {1'b0, op_b};
        q_bit   = ~diff[p_nbits];
        if (fn_q == MULDIV_MUL) begin
            acc_n  = mul_sum;
            op_a_n = op_a << 1;
            op_b_n = op_b >> 1;
        end else begin
            acc_n  = q_bit ? diff[p_nbits-1:0] : shifted[p_nbits-1:0];
            op_a_n = {op_a[p_nbits-2:0], q_bit};
            op_b_n = op_b;
        end
    end

    // Select the result from the final iteration and apply sign fix-up.
    always_comb begin
        case (fn_q)
            MULDIV_MUL:  final_val = acc_n;
            MULDIV_DIV:  final_val = neg_q ? -op_a_n : op_a_n;
            MULDIV_DIVU: final_val = op_a_n;
            MULDIV_REM:  final_val = neg_r ? -acc_n : acc_n;
            MULDIV_REMU: final_val = acc_n;
            default:     final_val = '0;
        endcase
    end

    // Operand and accumulator registers, loaded on accept and stepped in CALC.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fn_q  <= MULDIV_MUL;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            op_a  <= '0;
            op_b  <= '0;
            acc   <= '0;
        end else if (load) begin
            fn_q  <= req_msg_fn;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            op_a  <= a_mag;
            op_b  <= b_mag;
            acc   <= '0;
        end else if (step) begin
            op_a  <= op_a_n;
            op_b  <= op_b_n;
            acc   <= acc_n;
        end
    end

    // Result register, held stable while the response waits in DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result <= '0;
        end else if (load_special) begin
            result <= special_val;
        end else if (finish) begin
            result <= final_val;
        end
    end

    assign resp_msg = result;

endmodule

// File: rtl/lab2_proc_int_muldiv_iter.sv
// Iterative integer multiply/divide unit for the X stage. The top module
// holds the control FSM and iteration counter; arithmetic is in the dpath.
module lab2_proc_int_muldiv_iter
    import lab2_proc_muldiv_pkg::*;
#(
    parameter int p_nbits = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_val,
    output logic               req_rdy,
    input  logic [2:0]         req_msg_fn,
    input  logic [p_nbits-1:0] req_msg_a,
    input  logic [p_nbits-1:0] req_msg_b,
    output logic               resp_val,
    input  logic               resp_rdy,
    output logic [p_nbits-1:0] resp_msg
);

    localparam int CW = (p_nbits > 1) ? $clog2(p_nbits) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(p_nbits - 1);

    muldiv_state_e state;
    logic [CW-1:0] counter;

    logic accept;
    logic special;
    logic load;
    logic load_special;
    logic step;
    logic finish;

    // Handshake outputs and datapath control decoded from the current state.
    always_comb begin
        req_rdy      = (state == IDLE);
        resp_val     = (state == DONE);
        accept       = req_val && req_rdy;
        load         = accept && !special;
        load_special = accept && special;
        step         = (state == CALC);
        finish       = step && (counter == LAST_ITER);
    end

    // Control FSM: accept in IDLE, iterate p_nbits times in CALC, hold in DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            counter <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_val) begin
                        state   <= special ? DONE : CALC;
                        counter <= '0;
                    end
                end
                CALC: begin
                    if (counter == LAST_ITER) begin
                        state   <= DONE;
                        counter <= '0;
                    end else begin
                        counter <= counter + CW'(1);
                    end
                end
                DONE: begin
                    if (resp_rdy) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    counter <= '0;
                end
            endcase
        end
    end

    lab2_proc_int_muldiv_dpath #(
        .p_nbits(p_nbits)
    ) dpath (
        .clk          (clk),
        .reset        (reset),
        .load         (load),
        .load_special (load_special),
        .step         (step),
        .finish       (finish),
        .req_msg_fn   (req_msg_fn),
        .req_msg_a    (req_msg_a),
        .req_msg_b    (req_msg_b),
        .special      (special),
        .resp_msg     (resp_msg)
    );

endmodule
